pipeline_stage3_ex_mem: RTL and testbench
=========================================

Name: pipeline_stage3_ex_mem

Overview:
- EX/MEM boundary of the 16-bit pipeline. Sits directly downstream of the ID/EX register (stage 2) and the ALU.
- Registers the executed instruction and its controls for the memory/writeback side.
- Resolves branch/jump and issues a registered flush plus redirect target to the front end.
- Runs a data-memory wait handshake with a timeout; stalls upstream while memory is busy.

Parameters:
WIDTH, 16, datapath/address width
MEM_TIMEOUT, 8, max cycles an access may spend waiting for mem_ready (>=2); counter width is clog2(MEM_TIMEOUT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  stage-2 entry holds a real instruction
in_branch  in  1  conditional branch
in_jump  in  1  unconditional jump
in_Mem_WE  in  1  store
in_Mem_bypass  in  1  1 = no memory access (result bypasses memory)
in_ALU_bypass  in  1  writeback selects non-ALU source
in_instruction  in  WIDTH  instruction word
in_alu_result  in  WIDTH  ALU result / memory address
in_alu_zero  in  1  ALU zero flag (branch condition)
in_RD2  in  WIDTH  store data
in_target  in  WIDTH  branch/jump target
in_wa  in  WIDTH  write address
mem_ready  in  1  data memory completes the current access this cycle
out_valid  out  1  registered entry is real
out_Mem_WE, out_Mem_bypass, out_ALU_bypass  out  1 each  registered controls, gated by valid
out_instruction, out_alu_result, out_store_data, out_wa  out  WIDTH each  registered data
mem_req  out  1  memory access in progress
stall_out  out  1  hold stages 1-2 this cycle
flush_out  out  1  discard wrong-path instructions upstream
redirect_pc  out  WIDTH  fetch target, valid while flush_out=1
mem_err  out  1  sticky: an access timed out

Behaviour:
- Reset (async) clears every output and internal register to 0:
  - state = RUN, wait counter = 0, flush_pending = 0, mem_err = 0.
  - mem_req and stall_out fall in the same cycle reset asserts.
- hold = (state==WAIT_MEM) & ~mem_ready & (cnt != MEM_TIMEOUT-1).
- stall_out = hold; combinational.
- mem_req = (state==WAIT_MEM); combinational.
- Posedge with hold=1:
  - All pipeline registers, redirect_pc and flush_pending keep their values.
  - cnt increments.
  - No branch resolution.
- Posedge with hold=0 (capture):
  - If flush_pending=1: capture a bubble (out_valid=0, all control outs 0, data regs 0). Clear flush_pending.
  - Else: capture all inputs. out_valid=in_valid; control outs are AND-ed with in_valid.
  - Taken condition: in_valid & ((in_branch & in_alu_zero) | in_jump). If taken, and not capturing a bubble: flush_pending<=1, redirect_pc<=in_target.
  - If state==WAIT_MEM, mem_ready=0 and cnt==MEM_TIMEOUT-1: mem_err<=1, and the access is treated as complete.
- flush_out = flush_pending.
  - One cycle wide normally.
  - Stays high through any hold cycles, so the first entry captured after a taken branch is always a bubble.
- FSM:
  - RUN -> WAIT_MEM when the entry just captured has valid=1 & Mem_bypass=0; cnt<=0.
  - WAIT_MEM -> RUN on capture when the newly captured entry is not a memory access.
  - WAIT_MEM -> WAIT_MEM (cnt<=0) on capture when the new entry is again a memory access.
- Latency:
  - Non-memory instructions: 1 cycle, no stall.
  - Memory access: mem_req lasts 1..MEM_TIMEOUT cycles; done on the mem_ready cycle or on timeout.
- A branch that is also a memory access does both: flush_pending set, enters WAIT_MEM.
- mem_err is cleared only by reset.

Test Plan:
- ALU op: in_valid=1, Mem_bypass=1, alu_result=0x1234, wa=0x0003 -> next cycle out_valid=1, out_alu_result=0x1234, out_wa=0x0003, mem_req=0, stall_out=0.
- Load, mem_ready low 2 cycles then high -> mem_req high 3 cycles, stall_out high 2 cycles, outputs frozen; next instruction captured on the mem_ready edge.
- Taken branch in_branch=1, zero=1, target=0x0040 -> next cycle flush_out=1, redirect_pc=0x0040. The following capture has out_valid=0 despite in_valid=1, and flush_out then returns to 0. Same stimulus with zero=0 -> no flush.
- MEM_TIMEOUT=4, mem_ready stuck 0 on a store -> mem_req high exactly 4 cycles, stall_out 3 cycles, mem_err=1 thereafter, pipeline resumes.
- Jump with Mem_bypass=0 and mem_ready low 2 cycles -> flush_out held high 3 cycles; first captured entry after release is a bubble.
- Reset asserted mid-WAIT_MEM -> mem_req, stall_out, out_valid and mem_err 0 immediately; after release, first instruction behaves as from clean start.

Source files
------------

// File: rtl/pipeline_stage3_ex_mem.sv
// EX/MEM pipeline register: captures the executed instruction, resolves branches into a
// registered flush/redirect, and holds upstream while a data-memory access waits for mem_ready.
module pipeline_stage3_ex_mem #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_branch,
    input  logic             in_jump,
    input  logic             in_Mem_WE,
    input  logic             in_Mem_bypass,
    input  logic             in_ALU_bypass,
    input  logic [WIDTH-1:0] in_instruction,
    input  logic [WIDTH-1:0] in_alu_result,
    input  logic             in_alu_zero,
    input  logic [WIDTH-1:0] in_RD2,
    input  logic [WIDTH-1:0] in_target,
    input  logic [WIDTH-1:0] in_wa,
    input  logic             mem_ready,
    output logic             out_valid,
    output logic             out_Mem_WE,
    output logic             out_Mem_bypass,
    output logic             out_ALU_bypass,
    output logic [WIDTH-1:0] out_instruction,
    output logic [WIDTH-1:0] out_alu_result,
    output logic [WIDTH-1:0] out_store_data,
    output logic [WIDTH-1:0] out_wa,
    output logic             mem_req,
    output logic             stall_out,
    output logic             flush_out,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             mem_err
);

    localparam int unsigned     CntW   = $clog2(MEM_TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {StRun, StWaitMem} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             flush_q, flush_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] redirect_q, redirect_d;
    logic             valid_q, valid_d;
    logic             we_q, we_d;
    logic             mbyp_q, mbyp_d;
    logic             abyp_q, abyp_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] sdata_q, sdata_d;
    logic [WIDTH-1:0] wa_q, wa_d;

    logic waiting, hold, taken;

    assign waiting = (state_q == StWaitMem);
    // The last waiting cycle never holds: a timed-out access completes like a ready one.
    assign hold    = waiting & ~mem_ready & (cnt_q != CntMax);
    assign taken   = in_valid & ((in_branch & in_alu_zero) | in_jump);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        err_d      = err_q;
        redirect_d = redirect_q;
        valid_d    = valid_q;
        we_d       = we_q;
        mbyp_d     = mbyp_q;
        abyp_d     = abyp_q;
        instr_d    = instr_q;
        alu_d      = alu_q;
        sdata_d    = sdata_q;
        wa_d       = wa_q;

        if (hold) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            if (waiting && !mem_ready) begin
                err_d = 1'b1;
            end
            if (flush_q) begin
                // Wrong-path slot after a taken branch/jump becomes a bubble.
                valid_d = 1'b0;
                we_d    = 1'b0;
                mbyp_d  = 1'b0;
                abyp_d  = 1'b0;
                instr_d = '0;
                alu_d   = '0;
                sdata_d = '0;
                wa_d    = '0;
                flush_d = 1'b0;
            end else begin
                valid_d = in_valid;
                we_d    = in_Mem_WE & in_valid;
                mbyp_d  = in_Mem_bypass & in_valid;
                abyp_d  = in_ALU_bypass & in_valid;
                instr_d = in_instruction;
                alu_d   = in_alu_result;
                sdata_d = in_RD2;
                wa_d    = in_wa;
                if (taken) begin
                    flush_d    = 1'b1;
                    redirect_d = in_target;
                end
            end
            state_d = (valid_d && !mbyp_d) ? StWaitMem : StRun;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            err_q      <= 1'b0;
            redirect_q <= '0;
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            mbyp_q     <= 1'b0;
            abyp_q     <= 1'b0;
            instr_q    <= '0;
            alu_q      <= '0;
            sdata_q    <= '0;
            wa_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            err_q      <= err_d;
            redirect_q <= redirect_d;
            valid_q    <= valid_d;
            we_q       <= we_d;
            mbyp_q     <= mbyp_d;
            abyp_q     <= abyp_d;
            instr_q    <= instr_d;
            alu_q      <= alu_d;
            sdata_q    <= sdata_d;
            wa_q       <= wa_d;
        end
    end

    assign mem_req         = waiting;
    assign stall_out       = hold;
    assign flush_out       = flush_q;
    assign redirect_pc     = redirect_q;
    assign mem_err         = err_q;
    assign out_valid       = valid_q;
    assign out_Mem_WE      = we_q;
    assign out_Mem_bypass  = mbyp_q;
    assign out_ALU_bypass  = abyp_q;
    assign out_instruction = instr_q;
    assign out_alu_result  = alu_q;
    assign out_store_data  = sdata_q;
    assign out_wa          = wa_q;

endmodule

// File: tb/tb_pipeline_stage3_ex_mem.sv
// Scoreboard bench for the EX/MEM register: expected entries are queued at capture and
// compared after the edge; handshake/flush waveforms are counted per scenario.
module tb_pipeline_stage3_ex_mem;

    localparam int unsigned W  = 16;
    localparam int unsigned MT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_branch, in_jump, in_Mem_WE, in_Mem_bypass, in_ALU_bypass;
    logic [W-1:0] in_instruction, in_alu_result, in_RD2, in_target, in_wa;
    logic         in_alu_zero, mem_ready;
    logic         out_valid, out_Mem_WE, out_Mem_bypass, out_ALU_bypass;
    logic [W-1:0] out_instruction, out_alu_result, out_store_data, out_wa;
    logic         mem_req, stall_out, flush_out, mem_err;
    logic [W-1:0] redirect_pc;

    always #5 clk = ~clk;

    pipeline_stage3_ex_mem #(.WIDTH(W), .MEM_TIMEOUT(MT)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_branch      (in_branch),
        .in_jump        (in_jump),
        .in_Mem_WE      (in_Mem_WE),
        .in_Mem_bypass  (in_Mem_bypass),
        .in_ALU_bypass  (in_ALU_bypass),
        .in_instruction (in_instruction),
        .in_alu_result  (in_alu_result),
        .in_alu_zero    (in_alu_zero),
        .in_RD2         (in_RD2),
        .in_target      (in_target),
        .in_wa          (in_wa),
        .mem_ready      (mem_ready),
        .out_valid      (out_valid),
        .out_Mem_WE     (out_Mem_WE),
        .out_Mem_bypass (out_Mem_bypass),
        .out_ALU_bypass (out_ALU_bypass),
        .out_instruction(out_instruction),
        .out_alu_result (out_alu_result),
        .out_store_data (out_store_data),
        .out_wa         (out_wa),
        .mem_req        (mem_req),
        .stall_out      (stall_out),
        .flush_out      (flush_out),
        .redirect_pc    (redirect_pc),
        .mem_err        (mem_err)
    );

    typedef struct packed {
        logic [W-1:0] ins, alu, sd, wa;
        logic         v, we, byp, abyp;
    } entry_t;

    typedef struct packed {
        logic         v, br, jmp, we, byp, abyp, zero;
        logic [W-1:0] ins, alu, rd2, tgt, wa;
    } stim_t;

    entry_t       exp_q[$];
    entry_t       last_e;
    int           n_checks = 0;
    int           n_pass   = 0;
    logic         m_wait, m_flush, m_err;
    int           m_cnt;
    logic [W-1:0] m_redirect;
    int           n_req, n_stall, n_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_regs(input entry_t e);
        check("out_valid",       32'(out_valid),       32'(e.v));
        check("out_Mem_WE",      32'(out_Mem_WE),      32'(e.we));
        check("out_Mem_bypass",  32'(out_Mem_bypass),  32'(e.byp));
        check("out_ALU_bypass",  32'(out_ALU_bypass),  32'(e.abyp));
        check("out_instruction", 32'(out_instruction), 32'(e.ins));
        check("out_alu_result",  32'(out_alu_result),  32'(e.alu));
        check("out_store_data",  32'(out_store_data),  32'(e.sd));
        check("out_wa",          32'(out_wa),          32'(e.wa));
    endtask

    function automatic stim_t mk(input logic v, input logic br, input logic jmp,
                                 input logic we, input logic byp, input logic zero,
                                 input logic [W-1:0] alu, input logic [W-1:0] tgt,
                                 input logic [W-1:0] wa);
        stim_t s;
        s      = '0;
        s.v    = v;
        s.br   = br;
        s.jmp  = jmp;
        s.we   = we;
        s.byp  = byp;
        s.abyp = ~byp;
        s.zero = zero;
        s.alu  = alu;
        s.tgt  = tgt;
        s.wa   = wa;
        s.ins  = {alu[7:0], wa[7:0]};
        s.rd2  = ~alu;
        return s;
    endfunction

    task automatic model_reset();
        m_wait     = 1'b0;
        m_flush    = 1'b0;
        m_err      = 1'b0;
        m_cnt      = 0;
        m_redirect = '0;
        last_e     = '0;
        exp_q.delete();
    endtask

    task automatic clr();
        n_req   = 0;
        n_stall = 0;
        n_flush = 0;
    endtask

    // Called just after a rising edge; applies one cycle of stimulus and checks it.
    task automatic drive(input stim_t s, input logic rdy);
        logic   hold;
        logic   pushed;
        entry_t e;
        in_valid       = s.v;
        in_branch      = s.br;
        in_jump        = s.jmp;
        in_Mem_WE      = s.we;
        in_Mem_bypass  = s.byp;
        in_ALU_bypass  = s.abyp;
        in_alu_zero    = s.zero;
        in_instruction = s.ins;
        in_alu_result  = s.alu;
        in_RD2         = s.rd2;
        in_target      = s.tgt;
        in_wa          = s.wa;
        mem_ready      = rdy;
        #3;
        hold = m_wait && !rdy && (m_cnt != int'(MT) - 1);
        check("stall_out",   32'(stall_out),   32'(hold));
        check("mem_req",     32'(mem_req),     32'(m_wait));
        check("flush_out",   32'(flush_out),   32'(m_flush));
        check("redirect_pc", 32'(redirect_pc), 32'(m_redirect));
        if (mem_req)   n_req++;
        if (stall_out) n_stall++;
        if (flush_out) n_flush++;
        pushed = 1'b0;
        if (hold) begin
            m_cnt++;
        end else begin
            if (m_wait && !rdy) m_err = 1'b1;
            if (m_flush) begin
                e       = '0;
                m_flush = 1'b0;
            end else begin
                e.v    = s.v;
                e.we   = s.we & s.v;
                e.byp  = s.byp & s.v;
                e.abyp = s.abyp & s.v;
                e.ins  = s.ins;
                e.alu  = s.alu;
                e.sd   = s.rd2;
                e.wa   = s.wa;
                if (s.v && ((s.br && s.zero) || s.jmp)) begin
                    m_flush    = 1'b1;
                    m_redirect = s.tgt;
                end
            end
            exp_q.push_back(e);
            pushed = 1'b1;
            m_wait = e.v && !e.byp;
            m_cnt  = 0;
        end
        @(posedge clk);
        #1;
        if (pushed) last_e = exp_q.pop_front();
        check_regs(last_e);
        check("mem_err", 32'(mem_err), 32'(m_err));
    endtask

    stim_t nop, alu1, alu2, ld, st, br_t, br_n, jmp;

    initial begin
        nop  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        alu1 = mk(1, 0, 0, 0, 1, 0, 16'h1234, 16'h0000, 16'h0003);
        alu2 = mk(1, 0, 0, 0, 1, 0, 16'h5555, 16'h0000, 16'h0007);
        ld   = mk(1, 0, 0, 0, 0, 0, 16'h0100, 16'h0000, 16'h0002);
        st   = mk(1, 0, 0, 1, 0, 0, 16'h0200, 16'h0000, 16'h0000);
        br_t = mk(1, 1, 0, 0, 1, 1, 16'h0000, 16'h0040, 16'h0000);
        br_n = mk(1, 1, 0, 0, 1, 0, 16'h0001, 16'h0050, 16'h0000);
        jmp  = mk(1, 0, 1, 0, 0, 0, 16'h0300, 16'h0080, 16'h0004);

        reset = 1'b1;
        {in_valid, in_branch, in_jump, in_Mem_WE, in_Mem_bypass, in_ALU_bypass} = '0;
        {in_instruction, in_alu_result, in_RD2, in_target, in_wa} = '0;
        in_alu_zero = 1'b0;
        mem_ready   = 1'b0;
        model_reset();
        clr();
        repeat (2) @(posedge clk);
        #1;
        check_regs('0);
        check("rst_mem_req",   32'(mem_req),     32'd0);
        check("rst_stall",     32'(stall_out),   32'd0);
        check("rst_flush",     32'(flush_out),   32'd0);
        check("rst_redirect",  32'(redirect_pc), 32'd0);
        check("rst_mem_err",   32'(mem_err),     32'd0);
        reset = 1'b0;

        // Plain ALU op: one-cycle latency, no handshake.
        drive(alu1, 1'b0);
        check("alu_result", 32'(out_alu_result), 32'h1234);
        check("alu_wa",     32'(out_wa),         32'h0003);
        drive(nop, 1'b0);

        // Load with mem_ready low for two cycles.
        clr();
        drive(ld, 1'b1);
        drive(alu2, 1'b0);
        drive(alu2, 1'b0);
        drive(alu2, 1'b1);
        check("ld_req_cycles",   32'(n_req),          32'd3);
        check("ld_stall_cycles", 32'(n_stall),        32'd2);
        check("ld_next_capture", 32'(out_alu_result), 32'h5555);
        drive(nop, 1'b0);

        // Taken branch then a wrong-path instruction that must become a bubble.
        clr();
        drive(br_t, 1'b0);
        check("br_redirect", 32'(redirect_pc), 32'h0040);
        drive(alu1, 1'b0);
        check("br_bubble", 32'(out_valid), 32'd0);
        drive(nop, 1'b0);
        check("br_flush_cycles", 32'(n_flush), 32'd1);

        // Same branch, condition false: no flush.
        clr();
        drive(br_n, 1'b0);
        drive(alu1, 1'b0);
        drive(nop, 1'b0);
        check("nt_flush_cycles", 32'(n_flush), 32'd0);

        // Store whose memory never answers.
        clr();
        drive(st, 1'b1);
        repeat (MT) drive(nop, 1'b0);
        check("to_req_cycles",   32'(n_req),   32'd4);
        check("to_stall_cycles", 32'(n_stall), 32'd3);
        check("to_mem_err",      32'(mem_err), 32'd1);
        drive(alu2, 1'b0);
        check("to_resume", 32'(out_alu_result), 32'h5555);

        // Jump that is also a memory access: flush must span the hold cycles.
        clr();
        drive(jmp, 1'b1);
        drive(alu1, 1'b0);
        drive(alu1, 1'b0);
        drive(alu1, 1'b1);
        check("jmp_bubble", 32'(out_valid), 32'd0);
        drive(nop, 1'b0);
        check("jmp_flush_cycles", 32'(n_flush), 32'd3);

        // Reset in the middle of a memory wait.
        drive(ld, 1'b1);
        drive(nop, 1'b0);
        mem_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("mr_mem_req",   32'(mem_req),   32'd0);
        check("mr_stall",     32'(stall_out), 32'd0);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_mem_err",   32'(mem_err),   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(alu1, 1'b0);
        check("mr_after_alu", 32'(out_alu_result), 32'h1234);
        drive(nop, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
